// File: rtl/ram_dp_init_if.sv
// ram_dp_init_if: request/response bundle for the ram_dp_init dual-port RAM.
//   Write port : wr_cs, we, wr_address, data_in
//   Read port  : rd_cs, rd_address, oe
//   Responses  : data_out (oe-gated read data), rd_valid, busy, access_err
// master drives the requests (the bench or the client block); slave is the RAM.
interface ram_dp_init_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  wr_cs;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_cs;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic                  oe;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  busy;
  logic                  access_err;

  modport master (
    output wr_cs, we, wr_address, data_in, rd_cs, rd_address, oe,
    input  data_out, rd_valid, busy, access_err
  );

  modport slave (
    input  wr_cs, we, wr_address, data_in, rd_cs, rd_address, oe,
    output data_out, rd_valid, busy, access_err
  );
endinterface

// File: rtl/ram_dp_init.sv
// ram_dp_init: single-clock dual-port RAM (one write port, one read port) that
// clears itself to INIT_VALUE with a sweep after every reset.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : ram_dp_init_if slave modport
//           wr_cs/we/wr_address/data_in : write request (wr_cs & we)
//           rd_cs/rd_address            : read request, 1-cycle latency
//           oe                          : combinational gate on data_out
//           data_out/rd_valid           : registered read data and its valid
//           busy                        : init sweep running, requests refused
//           access_err                  : 1-cycle pulse, refused/out-of-range
module ram_dp_init #(
  parameter int unsigned           DATA_WIDTH  = 4,
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter int unsigned           DEPTH       = 2**ADDR_WIDTH,
  parameter bit                    WRITE_FIRST = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic         clk,
  input  logic         reset,
  ram_dp_init_if.slave bus
);

  // Array index width; may be narrower than the port address when DEPTH is
  // small. Out-of-range addresses never reach the array.
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic                  busy_q;
  logic                  rd_valid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] dout_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             ready;
  logic             wr_req;
  logic             rd_req;
  logic             wr_oor;
  logic             rd_oor;
  logic             wr_ok;
  logic             rd_ok;
  logic             collide;
  logic             err_next;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  always_comb begin
    ready    = (state == READY);
    wr_req   = bus.wr_cs & bus.we;
    rd_req   = bus.rd_cs;
    wr_oor   = ({1'b0, bus.wr_address} >= DEPTH_L);
    rd_oor   = ({1'b0, bus.rd_address} >= DEPTH_L);
    wr_ok    = ready & wr_req & ~wr_oor;
    rd_ok    = ready & rd_req & ~rd_oor;
    collide  = wr_ok & rd_ok & (bus.wr_address == bus.rd_address);
    wr_idx   = bus.wr_address[IDX_W-1:0];
    rd_idx   = bus.rd_address[IDX_W-1:0];
    // Refused while sweeping, or out of range once ready.
    err_next = (~ready & (wr_req | rd_req))
             | (ready & wr_req & wr_oor)
             | (ready & rd_req & rd_oor);
  end

  // Storage has no reset. The sweep is gated by reset so that holding reset
  // with the clock running leaves the contents untouched.
  always_ff @(posedge clk) begin
    if (reset && state == INIT) begin
      mem[ptr] <= INIT_VALUE;
    end else if (wr_ok) begin
      mem[wr_idx] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      ptr        <= '0;
      busy_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      err_q      <= err_next;
      // Out-of-range reads still complete (with zero data).
      rd_valid_q <= ready & rd_req;
      case (state)
        INIT: begin
          ptr <= ptr + IDX_W'(1);
          if (ptr == LAST) begin
            state  <= READY;
            busy_q <= 1'b0;
          end
        end
        READY: begin
          if (rd_req) begin
            if (rd_oor) begin
              dout_q <= '0;
            end else if (collide && WRITE_FIRST) begin
              dout_q <= bus.data_in;
            end else begin
              // Non-blocking array update means this is the pre-write value.
              dout_q <= mem[rd_idx];
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.data_out   = bus.oe ? dout_q : '0;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.busy       = busy_q;
  assign bus.access_err = err_q;

endmodule

// File: tb/tb_ram_dp_init.sv
// Directed bench for ram_dp_init. Three instances share clock, reset and
// stimulus: u0 defaults, u1 read-first collisions, u2 DEPTH=1000 with a
// non-zero INIT_VALUE.
module tb_ram_dp_init;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ram_dp_init_if #(.DATA_WIDTH(4), .ADDR_WIDTH(10)) bus0 ();
  ram_dp_init_if #(.DATA_WIDTH(4), .ADDR_WIDTH(10)) bus1 ();
  ram_dp_init_if #(.DATA_WIDTH(4), .ADDR_WIDTH(10)) bus2 ();

  ram_dp_init u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  ram_dp_init #(.WRITE_FIRST(1'b0)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  ram_dp_init #(.DEPTH(1000), .INIT_VALUE(4'h6)) u2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic cs, input logic w, input logic [9:0] a, input logic [3:0] d);
    bus0.wr_cs = cs; bus0.we = w; bus0.wr_address = a; bus0.data_in = d;
    bus1.wr_cs = cs; bus1.we = w; bus1.wr_address = a; bus1.data_in = d;
    bus2.wr_cs = cs; bus2.we = w; bus2.wr_address = a; bus2.data_in = d;
  endtask

  task automatic set_rd(input logic cs, input logic [9:0] a);
    bus0.rd_cs = cs; bus0.rd_address = a;
    bus1.rd_cs = cs; bus1.rd_address = a;
    bus2.rd_cs = cs; bus2.rd_address = a;
  endtask

  task automatic set_oe(input logic o);
    bus0.oe = o; bus1.oe = o; bus2.oe = o;
  endtask

  // Releases reset and counts edges until each instance drops busy.
  // When inject is set, a write @7 is offered on the first sweep edge.
  task automatic sweep(input bit inject, output int d0, output int d1, output int d2);
    int n;
    d0 = 0; d1 = 0; d2 = 0;
    reset = 1'b1;
    if (inject) set_wr(1'b1, 1'b1, 10'd7, 4'h5);
    n = 0;
    while (n < 1100 && (d0 == 0 || d1 == 0 || d2 == 0)) begin
      cycle();
      n++;
      if (inject && n == 1) begin
        check("busy_refuse_err0", bus0.access_err, 1);
        check("busy_refuse_err2", bus2.access_err, 1);
        set_wr(1'b0, 1'b0, 10'd0, 4'h0);
      end
      if (inject && n == 2) check("busy_refuse_err_clear", bus0.access_err, 0);
      if (d0 == 0 && bus0.busy === 1'b0) d0 = n;
      if (d1 == 0 && bus1.busy === 1'b0) d1 = n;
      if (d2 == 0 && bus2.busy === 1'b0) d2 = n;
    end
  endtask

  initial begin
    int d0, d1, d2;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    set_wr(1'b0, 1'b0, 10'd0, 4'h0);
    set_rd(1'b0, 10'd0);
    set_oe(1'b1);

    // Reset state
    repeat (3) cycle();
    check("rst_busy",     bus0.busy,       1);
    check("rst_rd_valid", bus0.rd_valid,   0);
    check("rst_err",      bus0.access_err, 0);
    check("rst_data",     bus0.data_out,   0);

    // Init sweep with a refused write @7
    sweep(1'b1, d0, d1, d2);
    check("sweep_len_u0", d0, 1024);
    check("sweep_len_u1", d1, 1024);
    check("sweep_len_u2", d2, 1000);

    // Back-to-back reads after init
    set_rd(1'b1, 10'd0);
    cycle();
    check("rd0_valid", bus0.rd_valid, 1);
    check("rd0_u0",    bus0.data_out, 4'h0);
    check("rd0_u2",    bus2.data_out, 4'h6);
    set_rd(1'b1, 10'd511);
    cycle();
    check("rd511_valid", bus0.rd_valid, 1);
    check("rd511_u0",    bus0.data_out, 4'h0);
    check("rd511_u2",    bus2.data_out, 4'h6);
    set_rd(1'b1, 10'd7);
    cycle();
    check("rd7_u0", bus0.data_out, 4'h0);
    check("rd7_u2", bus2.data_out, 4'h6);
    set_rd(1'b1, 10'd1023);
    cycle();
    check("rd1023_u0",    bus0.data_out,   4'h0);
    check("rd1023_err0",  bus0.access_err, 0);
    check("rd1023_u2",    bus2.data_out,   4'h0);
    check("rd1023_vld2",  bus2.rd_valid,   1);
    check("rd1023_err2",  bus2.access_err, 1);
    set_rd(1'b0, 10'd0);
    cycle();
    check("idle_valid", bus0.rd_valid,   0);
    check("idle_err2",  bus2.access_err, 0);

    // Write then read, with and without oe
    set_wr(1'b1, 1'b1, 10'd120, 4'hA);
    cycle();
    check("wr120_err", bus0.access_err, 0);
    set_wr(1'b0, 1'b0, 10'd0, 4'h0);
    set_rd(1'b1, 10'd120);
    cycle();
    check("rd120_data",  bus0.data_out, 4'hA);
    check("rd120_valid", bus0.rd_valid, 1);
    set_oe(1'b0);
    cycle();
    check("rd120_oe0_data",  bus0.data_out, 4'h0);
    check("rd120_oe0_valid", bus0.rd_valid, 1);
    set_oe(1'b1);
    #1;
    check("oe_comb", bus0.data_out, 4'hA);
    set_rd(1'b0, 10'd0);

    // Collision
    set_wr(1'b1, 1'b1, 10'd111, 4'h3);
    cycle();
    set_wr(1'b1, 1'b1, 10'd111, 4'hF);
    set_rd(1'b1, 10'd111);
    cycle();
    check("coll_wf_u0", bus0.data_out, 4'hF);
    check("coll_rf_u1", bus1.data_out, 4'h3);
    check("coll_wf_u2", bus2.data_out, 4'hF);
    set_wr(1'b0, 1'b0, 10'd0, 4'h0);
    cycle();
    check("coll_after_u0", bus0.data_out, 4'hF);
    check("coll_after_u1", bus1.data_out, 4'hF);
    set_rd(1'b0, 10'd0);

    // wr_cs without we is a no-op
    set_wr(1'b1, 1'b0, 10'd120, 4'h0);
    cycle();
    check("noop_err", bus0.access_err, 0);
    set_wr(1'b0, 1'b0, 10'd0, 4'h0);
    set_rd(1'b1, 10'd120);
    cycle();
    check("noop_data", bus0.data_out, 4'hA);
    set_rd(1'b0, 10'd0);

    // Out of range on u2 (in range on u0)
    set_wr(1'b1, 1'b1, 10'd1010, 4'hC);
    cycle();
    check("oor_wr_err2", bus2.access_err, 1);
    check("oor_wr_err0", bus0.access_err, 0);
    set_wr(1'b0, 1'b0, 10'd0, 4'h0);
    cycle();
    check("oor_err_not_sticky", bus2.access_err, 0);
    set_rd(1'b1, 10'd1010);
    cycle();
    check("oor_rd_data2",  bus2.data_out,   4'h0);
    check("oor_rd_valid2", bus2.rd_valid,   1);
    check("oor_rd_err2",   bus2.access_err, 1);
    check("oor_rd_data0",  bus0.data_out,   4'hC);
    set_rd(1'b0, 10'd0);

    // Reset during a pending read
    set_wr(1'b1, 1'b1, 10'd3, 4'h9);
    cycle();
    set_wr(1'b0, 1'b0, 10'd0, 4'h0);
    set_rd(1'b1, 10'd3);
    cycle();
    check("pre_rst_data",  bus0.data_out, 4'h9);
    check("pre_rst_valid", bus0.rd_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", bus0.rd_valid, 0);
    check("mid_rst_busy",  bus0.busy,     1);
    check("mid_rst_data",  bus0.data_out, 4'h0);
    check("mid_rst_busy2", bus2.busy,     1);
    set_rd(1'b0, 10'd0);
    repeat (2) cycle();
    sweep(1'b0, d0, d1, d2);
    check("resweep_len_u0", d0, 1024);
    check("resweep_len_u2", d2, 1000);
    set_rd(1'b1, 10'd3);
    cycle();
    check("resweep_rd3_u0", bus0.data_out, 4'h0);
    check("resweep_rd3_u1", bus1.data_out, 4'h0);
    check("resweep_rd3_u2", bus2.data_out, 4'h6);
    set_rd(1'b0, 10'd0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dp_init.md
# ram_dp_init

Parametrised single-clock dual-port RAM: one write port and one independent read port, usable in the same cycle, with configurable data width, address width and depth. It succeeds the single-port 4-bit × 1024 `ram` and keeps its `cs`/`we`/`oe` control style. After every reset a built-in sweep clears the array to a known value. Collision behaviour, out-of-range handling and access errors are fully defined. It sits behind the same interface-style bench and is the storage primitive for the next buffering blocks.

## Interface
- DATA_WIDTH, 4, width of each word
- ADDR_WIDTH, 10, width of both address ports
- DEPTH, 2**ADDR_WIDTH, number of words; legal range 2..2**ADDR_WIDTH
- WRITE_FIRST, 1, read/write collision mode: 1 = read returns new data, 0 = read returns old data
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the init sweep

- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- wr_cs  input  1  write-port select
- we  input  1  write enable; a write is requested when wr_cs=1 and we=1
- wr_address  input  ADDR_WIDTH  write address
- data_in  input  DATA_WIDTH  write data
- rd_cs  input  1  read-port select; a read is requested when rd_cs=1
- rd_address  input  ADDR_WIDTH  read address
- oe  input  1  output enable; combinationally gates data_out
- data_out  output  DATA_WIDTH  read data; registered value when oe=1, all zeros when oe=0
- rd_valid  output  1  high for the cycle in which the registered read data is valid
- busy  output  1  init sweep in progress; all requests are refused
- access_err  output  1  one-cycle pulse: a request was refused or was out of range

## Operation
- FSM has two states, INIT and READY.
- While reset=0:
  - state=INIT, sweep pointer=0.
  - busy=1, rd_valid=0, access_err=0, data register=0.
  - Array contents are not touched.
- INIT:
  - Each clock writes INIT_VALUE to the sweep pointer address, then increments the pointer.
  - After the write to DEPTH-1 the FSM moves to READY.
- READY: serves external requests. The FSM never returns to INIT except through reset.
- A request (write: wr_cs&we; read: rd_cs) arriving while busy=1 is dropped and access_err=1 on the next cycle.
- Accepted write: mem[wr_address] <= data_in at the edge.
- Accepted read: data register <= mem[rd_address] at the edge, and rd_valid=1 for the following cycle. Otherwise rd_valid=0 and the data register holds its value.
- Collision (read and write accepted to the same address in the same cycle):
  - WRITE_FIRST=1: read returns data_in.
  - WRITE_FIRST=0: read returns the previous contents.
  - The write always completes.
- Out of range (address ≥ DEPTH, possible only when DEPTH < 2**ADDR_WIDTH):
  - Write is dropped.
  - Read loads 0 into the data register with rd_valid=1.
  - access_err=1 on the next cycle.
- access_err is the registered OR of all error causes in a cycle. It is never sticky.
- wr_cs=1 with we=0 is a no-op: no write and no error.

## Timing
- Reset assertion is immediate (asynchronous). Reset release is sampled on clk edges.
- Init sweep:
  - busy stays high for exactly DEPTH rising edges after reset is released.
  - First edge writes address 0; edge DEPTH writes DEPTH-1 and clears busy.
  - A request is first accepted on the edge after busy is seen low.
- Write latency:
  - Data is visible to a read issued on the next edge.
  - Same-edge visibility is set by WRITE_FIRST.
- Read latency is 1 cycle: request at edge N, data_out/rd_valid valid after edge N, through edge N+1.
- Back-to-back reads on every cycle give rd_valid held continuously high.
- oe has zero latency (combinational gating). rd_valid ignores oe.
- Reset asserted mid-sweep or mid-operation:
  - Outputs go to reset values at once.
  - The sweep restarts from address 0 after reset is released.
  - Any in-flight read is discarded (rd_valid=0).
- Port data widths track DATA_WIDTH exactly, with no truncation or extension.

## Test plan
- Reset/init (defaults): release reset → busy=1 for 1024 cycles, then 0; reads of addresses 0, 511 and 1023 return 4'h0 with rd_valid one cycle after each request.
- Write/read: write 4'hA @120, then read @120 with oe=1 → data_out=4'hA one cycle later; the same read with oe=0 → data_out=0, rd_valid=1.
- Collision: mem[111]=4'h3, then write 4'hF @111 and read @111 in the same cycle:
  - WRITE_FIRST=1 → read returns 4'hF.
  - WRITE_FIRST=0 → read returns 4'h3.
  - A later read of @111 returns 4'hF in both modes.
- Busy refusal: write 4'h5 @7 during the sweep → access_err pulses for one cycle; after init, a read of @7 returns INIT_VALUE.
- Out of range (DEPTH=1000): write @1010 → access_err pulse, no write; read @1010 → data_out=0, rd_valid=1, access_err pulse.
- Reset mid-operation: write 4'h9 @3, then assert reset during a pending read → rd_valid=0 at once; busy=1 for 1024 cycles after release; @3 then reads 4'h0.
